// File: rtl/io_output_port_pkg.sv
// io_output_port_pkg
//   Shared definitions for the memory-mapped output port controller:
//   register offsets within the I/O window, converter FSM states and
//   the seven-segment constants used at reset and on overflow.
package io_output_port_pkg;

    // Register index taken from addr[4:2]
    localparam logic [2:0] PORT0 = 3'd0;
    localparam logic [2:0] PORT1 = 3'd1;
    localparam logic [2:0] PORT2 = 3'd2;
    localparam logic [2:0] LED   = 3'd3;

    // Largest value a port can show as two decimal digits
    localparam logic [31:0] PORT_MAX = 32'd99;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } conv_state_t;

    // Active-low segments, bit order gfedcba
    localparam logic [6:0] SEG_ZERO = 7'b1000000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

endpackage

// File: rtl/io_output_port_if.sv
// io_output_port_if
//   CPU data-bus view of the I/O region.
//   addr         : byte address (word aligned)
//   datain       : store data
//   wmem         : store strobe
//   io_read_data : combinational read-back of the selected register
//   master modport = CPU side, slave modport = port controller side.
interface io_output_port_if;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        wmem;
    logic [31:0] io_read_data;

    modport master (output addr, output datain, output wmem, input io_read_data);
    modport slave  (input addr, input datain, input wmem, output io_read_data);
endinterface

// File: rtl/io_output_port_sevenseg_decoder.sv
// sevenseg_decoder
//   Combinational BCD digit to active-low seven-segment pattern (gfedcba).
//   bcd : 4-bit digit, 0..9
//   seg : segment pattern; non-decimal codes show a dash
module sevenseg_decoder
    import io_output_port_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/io_output_port.sv
// io_output_port
//   Memory-mapped output port controller. CPU stores into the I/O region
//   update three numeric ports and an LED register; one shared sequential
//   binary-to-BCD converter refreshes the seven-segment pair of each port.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : CPU address/data/strobe and read-back (slave modport)
//   led          : LED register
//   hex0..hex5   : active-low segment outputs (hex1:hex0 = port0,
//                  hex3:hex2 = port1, hex5:hex4 = port2; tens on odd digit)
//   busy         : a conversion is pending or in progress
module io_output_port
    import io_output_port_pkg::*;
#(
    parameter int unsigned IO_SEL_BIT = 7,
    parameter int unsigned CONV_BITS  = 7
) (
    input  logic              clock,
    input  logic              reset,
    io_output_port_if.slave   bus,
    output logic [9:0]        led,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic [6:0]        hex2,
    output logic [6:0]        hex3,
    output logic [6:0]        hex4,
    output logic [6:0]        hex5,
    output logic              busy
);
    localparam logic [2:0] CNT_LAST = 3'(CONV_BITS - 1);

    logic               io_sel;
    logic [2:0]         reg_sel;
    logic               wr_en;
    logic [31:0]        port_q [3];
    logic [2:0]         dirty;
    logic [2:0]         dirty_set;
    logic [2:0]         dirty_clr;

    conv_state_t        state, next_state;
    logic               load;
    logic [1:0]         pick;
    logic [1:0]         sel_q;
    logic [CONV_BITS-1:0] shreg;
    logic [7:0]         bcd;
    logic [7:0]         bcd_adj;
    logic [2:0]         cnt;
    logic               ovf;
    logic [6:0]         tens_dec, units_dec;
    logic [6:0]         tens_seg, units_seg;

    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.addr, bus.datain};

    assign io_sel  = bus.addr[IO_SEL_BIT];
    assign reg_sel = bus.addr[4:2];
    assign wr_en   = bus.wmem & io_sel;
    assign busy    = (state != IDLE) | (|dirty);

    always_comb begin
        bus.io_read_data = '0;
        if (io_sel) begin
            case (reg_sel)
                PORT0:   bus.io_read_data = port_q[0];
                PORT1:   bus.io_read_data = port_q[1];
                PORT2:   bus.io_read_data = port_q[2];
                LED:     bus.io_read_data = {22'd0, led};
                default: bus.io_read_data = '0;
            endcase
        end
    end

    always_comb begin
        dirty_set = '0;
        if (wr_en) begin
            case (reg_sel)
                PORT0:   dirty_set[0] = 1'b1;
                PORT1:   dirty_set[1] = 1'b1;
                PORT2:   dirty_set[2] = 1'b1;
                default: dirty_set = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        pick       = 2'd0;
        dirty_clr  = '0;
        case (state)
            IDLE: begin
                if (|dirty) begin
                    load       = 1'b1;
                    next_state = SHIFT;
                    if (dirty[0])      pick = 2'd0;
                    else if (dirty[1]) pick = 2'd1;
                    else               pick = 2'd2;
                    dirty_clr = 3'b001 << pick;
                end
            end
            SHIFT:   if (cnt == CNT_LAST) next_state = UPDATE;
            UPDATE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Double-dabble correction applied before each left shift
    always_comb begin
        bcd_adj = bcd;
        if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
        if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
    end

    sevenseg_decoder u_dec_tens  (.bcd(bcd[7:4]), .seg(tens_dec));
    sevenseg_decoder u_dec_units (.bcd(bcd[3:0]), .seg(units_dec));

    assign tens_seg  = ovf ? SEG_DASH : tens_dec;
    assign units_seg = ovf ? SEG_DASH : units_dec;

    always_ff @(posedge clock) begin
        if (reset) begin
            port_q[0] <= '0;
            port_q[1] <= '0;
            port_q[2] <= '0;
            led       <= '0;
            dirty     <= '0;
            sel_q     <= '0;
            shreg     <= '0;
            bcd       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            hex0      <= SEG_ZERO;
            hex1      <= SEG_ZERO;
            hex2      <= SEG_ZERO;
            hex3      <= SEG_ZERO;
            hex4      <= SEG_ZERO;
            hex5      <= SEG_ZERO;
        end else begin
            if (wr_en) begin
                case (reg_sel)
                    PORT0:   port_q[0] <= bus.datain;
                    PORT1:   port_q[1] <= bus.datain;
                    PORT2:   port_q[2] <= bus.datain;
                    LED:     led       <= bus.datain[9:0];
                    default: ;
                endcase
            end
            // Set is OR-ed in after the clear so a same-edge rewrite stays pending
            dirty <= (dirty & ~dirty_clr) | dirty_set;

            if (load) begin
                sel_q <= pick;
                shreg <= port_q[pick][CONV_BITS-1:0];
                bcd   <= '0;
                cnt   <= '0;
                ovf   <= port_q[pick] > PORT_MAX;
            end

            if (state == SHIFT) begin
                {bcd, shreg} <= {bcd_adj, shreg} << 1;
                cnt          <= cnt + 3'd1;
            end

            if (state == UPDATE) begin
                case (sel_q)
                    2'd0: begin hex1 <= tens_seg; hex0 <= units_seg; end
                    2'd1: begin hex3 <= tens_seg; hex2 <= units_seg; end
                    default: begin hex5 <= tens_seg; hex4 <= units_seg; end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_io_output_port.sv
// tb_io_output_port
//   Directed stimulus with a scoreboard of expected display-pair updates;
//   a monitor compares each observed pair change against the queue head.
module tb_io_output_port;
    import io_output_port_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] led;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic       busy;

    io_output_port_if bus();

    io_output_port #(.IO_SEL_BIT(7), .CONV_BITS(7)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .led   (led),
        .hex0  (hex0),
        .hex1  (hex1),
        .hex2  (hex2),
        .hex3  (hex3),
        .hex4  (hex4),
        .hex5  (hex5),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned pair;
        logic [6:0]  tens;
        logic [6:0]  units;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    function automatic logic [6:0] seg(int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic push(int unsigned pair, logic [6:0] t, logic [6:0] u);
        exp_t e;
        e.pair = pair; e.tens = t; e.units = u;
        sb.push_back(e);
    endtask

    // Returns 1 time unit after the store edge E
    task automatic cpu_write(logic [31:0] a, logic [31:0] d);
        @(negedge clock); #1;
        bus.addr = a; bus.datain = d; bus.wmem = 1'b1;
        @(posedge clock); #1;
        bus.wmem = 1'b0;
    endtask

    task automatic read_check(string name, logic [31:0] a, logic [31:0] exp);
        bus.addr = a;
        #1;
        check(name, bus.io_read_data, exp);
    endtask

    task automatic cycles(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Monitor: every change of a display pair outside reset must match the queue head
    initial begin : monitor
        logic [41:0] prev, cur;
        exp_t e;
        prev = '0;
        forever begin
            @(negedge clock);
            cur = {hex5, hex4, hex3, hex2, hex1, hex0};
            if (!reset && cur !== prev) begin
                for (int p = 0; p < 3; p++) begin
                    if (cur[p*14 +: 14] !== prev[p*14 +: 14]) begin
                        if (sb.size() == 0) begin
                            n_total++;
                            $display("FAIL unexpected_update: pair %0d changed to 0x%0h with nothing expected",
                                     p, cur[p*14 +: 14]);
                        end else begin
                            e = sb.pop_front();
                            check("sb_pair",  32'(p), 32'(e.pair));
                            check("sb_tens",  32'(cur[p*14+7 +: 7]), 32'(e.tens));
                            check("sb_units", 32'(cur[p*14 +: 7]),   32'(e.units));
                        end
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin
        bus.addr = '0; bus.datain = '0; bus.wmem = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        check("rst_hex", {hex5, hex4, hex3, hex2, hex1, hex0} , {6{SEG_ZERO}});
        check("rst_led", 32'(led), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        read_check("rst_read80", 32'h80, 32'd0);

        // 42 -> port0, exact latency
        push(0, seg(4), seg(2));
        cpu_write(32'h80, 32'd42);
        check("busy_at_E", 32'(busy), 32'd1);
        cycles(8);
        check("hex0_before_E9", 32'(hex0), 32'(SEG_ZERO));
        cycles(1);
        check("hex1_at_E9", 32'(hex1), 32'(seg(4)));
        check("hex0_at_E9", 32'(hex0), 32'(seg(2)));
        check("busy_after_E9", 32'(busy), 32'd0);
        read_check("read80_42", 32'h80, 32'd42);

        // Overflow on port1
        push(1, SEG_DASH, SEG_DASH);
        cpu_write(32'h84, 32'd123);
        cycles(9);
        check("hex3_dash", 32'(hex3), 32'(SEG_DASH));
        check("hex2_dash", 32'(hex2), 32'(SEG_DASH));
        read_check("read84_123", 32'h84, 32'd123);

        // Back-to-back stores: conversion order port2, port0, port1
        push(2, seg(0), seg(7));
        push(0, seg(0), seg(5));
        push(1, seg(0), seg(9));
        cpu_write(32'h88, 32'd7);
        cpu_write(32'h80, 32'd5);
        cpu_write(32'h84, 32'd9);
        cycles(30);
        check("hex5_07", 32'(hex5), 32'(seg(0)));
        check("hex4_07", 32'(hex4), 32'(seg(7)));
        check("hex1_05", 32'(hex1), 32'(seg(0)));
        check("hex0_05", 32'(hex0), 32'(seg(5)));
        check("hex3_09", 32'(hex3), 32'(seg(0)));
        check("hex2_09", 32'(hex2), 32'(seg(9)));
        check("busy_idle", 32'(busy), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
        read_check("read88_7", 32'h88, 32'd7);

        // LED register, non-I/O store, unmapped offset
        cpu_write(32'h8C, 32'h3FF);
        check("led_3ff", 32'(led), 32'h3FF);
        read_check("read8c_led", 32'h8C, 32'h3FF);
        cpu_write(32'h0C, 32'h155);
        check("led_non_io", 32'(led), 32'h3FF);
        check("busy_non_io", 32'(busy), 32'd0);
        read_check("read0c_non_io", 32'h0C, 32'd0);
        cpu_write(32'h90, 32'd55);
        check("busy_unmapped", 32'(busy), 32'd0);
        read_check("read90_zero", 32'h90, 32'd0);
        read_check("read80_still5", 32'h80, 32'd5);

        // Reset in the middle of a conversion
        cpu_write(32'h80, 32'd88);
        cycles(3);
        reset = 1'b1;
        cycles(1);
        check("midrst_hex", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{SEG_ZERO}});
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_led", 32'(led), 32'd0);
        @(negedge clock); #1;
        reset = 1'b0;
        cycles(15);
        check("post_rst_hex", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{SEG_ZERO}});
        check("post_rst_busy", 32'(busy), 32'd0);
        read_check("post_rst_read80", 32'h80, 32'd0);
        check("sb_final_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
